// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by uart_rx and uart_tx.
//   DATA_BITS     : payload width of one frame
//   uart_state_e  : receiver/transmitter FSM encodings
//   clks_per_bit(): rounded clock-to-baud divider
package uart_pkg;
  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_IDLE
  } uart_state_e;

  // Round to the nearest integer divider so the bit period error stays minimal.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: byte-output side of the UART receiver.
//   data/data_valid/data_ready : valid/ready holding register
//   busy                       : receiver mid-frame
//   frame_err/overrun/parity_err : one-cycle error pulses
// master = receiver, slave = consumer.
interface uart_rx_if;
  import uart_pkg::*;
  logic [DATA_BITS-1:0] data;
  logic                 data_valid;
  logic                 data_ready;
  logic                 busy;
  logic                 frame_err;
  logic                 overrun;
  logic                 parity_err;

  modport master (output data, data_valid, busy, frame_err, overrun, parity_err,
                  input  data_ready);
  modport slave  (input  data, data_valid, busy, frame_err, overrun, parity_err,
                  output data_ready);
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous bit.
//   i_clk, i_rst_n : destination clock, async active-low reset
//   i_d            : asynchronous input
//   o_q            : synchronised output (2-cycle latency)
// RESET_VAL sets both flops on reset (1 for an idle-high serial line).
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);
  logic r_meta, r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RESET_VAL;
      r_q    <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver (8E1 when UART_RX_PARITY_EN is defined).
//   clk_25mhz : system clock
//   resetn    : async active-low reset
//   rx        : serial line, idle high, asynchronous
//   bus       : uart_rx_if.master -- byte holding register (data/data_valid/
//               data_ready), busy, and error pulses frame_err/overrun/parity_err
// Frames are sampled mid-bit, LSB first. A finished good frame is handed to the
// holding register one cycle after its stop sample.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 25_000_000,
  parameter int BAUD   = 115_200
) (
  input  logic      clk_25mhz,
  input  logic      resetn,
  input  logic      rx,
  uart_rx_if.master bus
);
  localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam int BW           = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(HALF_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic                 w_rx_s;
  logic                 w_bit_end;
  logic                 w_par_ok;
  uart_state_e          r_state;
  logic [CW-1:0]        r_cnt;
  logic [BW-1:0]        r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_deliver;
  logic                 r_ferr;
  logic                 r_ovr;
  logic                 r_perr;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .i_clk  (clk_25mhz),
    .i_rst_n(resetn),
    .i_d    (rx),
    .o_q    (w_rx_s)
  );

  assign w_bit_end = (r_cnt == BIT_END);

`ifdef UART_RX_PARITY_EN
  logic r_par;
  // Even parity: the parity bit equals the XOR of the data bits.
  assign w_par_ok = (r_par == ^r_shift);
`else
  assign w_par_ok = 1'b1;
`endif

  always_ff @(posedge clk_25mhz or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_deliver <= 1'b0;
      r_ferr    <= 1'b0;
      r_ovr     <= 1'b0;
      r_perr    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par     <= 1'b0;
`endif
    end else begin
      r_deliver <= 1'b0;
      r_ferr    <= 1'b0;
      r_ovr     <= 1'b0;
      r_perr    <= 1'b0;
      r_cnt     <= r_cnt + CW'(1);

      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (!w_rx_s) r_state <= ST_START;
        end
        // Re-check the start bit at its midpoint to reject short glitches.
        ST_START: if (r_cnt == HALF_END) begin
          r_cnt   <= '0;
          r_bit   <= '0;
          r_state <= w_rx_s ? ST_IDLE : ST_DATA;
        end
        ST_DATA: if (w_bit_end) begin
          r_cnt   <= '0;
          r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
          r_bit   <= r_bit + BW'(1);
`ifdef UART_RX_PARITY_EN
          if (r_bit == LAST_BIT) r_state <= ST_PARITY;
`else
          if (r_bit == LAST_BIT) r_state <= ST_STOP;
`endif
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: if (w_bit_end) begin
          r_cnt   <= '0;
          r_par   <= w_rx_s;
          r_state <= ST_STOP;
        end
`endif
        // A bad parity drops the byte but the stop bit is still judged, so
        // a frame can raise both errors.
        ST_STOP: if (w_bit_end) begin
          r_cnt  <= '0;
          r_perr <= !w_par_ok;
          if (w_rx_s) begin
            r_deliver <= w_par_ok;
            r_state   <= ST_IDLE;
          end else begin
            r_ferr  <= 1'b1;
            r_state <= ST_WAIT_IDLE;
          end
        end
        // Hold off on a break / stuck-low line until it returns high.
        ST_WAIT_IDLE: begin
          r_cnt <= '0;
          if (w_rx_s) r_state <= ST_IDLE;
        end
        default: begin
          r_cnt   <= '0;
          r_state <= ST_IDLE;
        end
      endcase

      // Holding register: a consumer pop in the same cycle frees the slot.
      if (r_deliver) begin
        if (!r_valid || bus.data_ready) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (r_valid && bus.data_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.data       = r_data;
  assign bus.data_valid = r_valid;
  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.frame_err  = r_ferr;
  assign bus.overrun    = r_ovr;
  assign bus.parity_err = r_perr;
endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
  localparam int CPB  = 217;
  localparam int HALF = 108;
`ifdef UART_RX_PARITY_EN
  localparam int LAT  = 2 + HALF + 10 * CPB + 1;
`else
  localparam int LAT  = 2 + HALF + 9 * CPB + 1;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic rx = 1'b1;
  always #20 clk = ~clk;

  uart_rx_if u_if ();
  uart_rx dut (.clk_25mhz(clk), .resetn(resetn), .rx(rx), .bus(u_if));

  int n_chk = 0;
  int n_err = 0;

  // Free-running cycle count and output monitor sampled mid-cycle.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int mon_rises = 0, mon_ferr = 0, mon_ovr = 0, mon_perr = 0, rise_cyc = 0;
  logic [7:0] hist [16];
  logic prev_dv = 1'b0;
  always @(negedge clk) begin
    if (u_if.data_valid && !prev_dv) begin
      hist[mon_rises % 16] = u_if.data;
      mon_rises = mon_rises + 1;
      rise_cyc  = cyc;
    end
    prev_dv = u_if.data_valid;
    if (u_if.frame_err)  mon_ferr = mon_ferr + 1;
    if (u_if.overrun)    mon_ovr  = mon_ovr + 1;
    if (u_if.parity_err) mon_perr = mon_perr + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  int t_fall = 0;
  task automatic hold_bit(input logic v);
    rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  // Start bit, 8 data bits LSB first, optional parity, stop bit.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_flip);
    @(negedge clk);
    t_fall = cyc;
    hold_bit(1'b0);
    for (int i = 0; i < 8; i++) hold_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    hold_bit((^b) ^ par_flip);
`else
    if (par_flip) rx = 1'b1;
`endif
    hold_bit(stop);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] b;
    logic       stop;
    int         exp_rises;
    logic [7:0] exp_data;
    int         exp_ferr;
  } vec_t;
  vec_t vecs [6];

  int r0, f0, o0, p0;
  int busy_clr;

  initial begin
    vecs[0] = '{8'h55, 1'b1, 1, 8'h55, 0};
    vecs[1] = '{8'h00, 1'b1, 1, 8'h00, 0};
    vecs[2] = '{8'hFF, 1'b1, 1, 8'hFF, 0};
    vecs[3] = '{8'h80, 1'b1, 1, 8'h80, 0};
    vecs[4] = '{8'h01, 1'b1, 1, 8'h01, 0};
    vecs[5] = '{8'hC3, 1'b0, 0, 8'h00, 1};

    u_if.data_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset data",       int'(u_if.data), 0);
    chk("reset data_valid", int'(u_if.data_valid), 0);
    chk("reset busy",       int'(u_if.busy), 0);
    chk("reset flags",      int'({u_if.frame_err, u_if.overrun, u_if.parity_err}), 0);
    resetn = 1'b1;
    idle(10);

    // Table-driven frames; first entry also checks end-to-end latency.
    foreach (vecs[k]) begin
      r0 = mon_rises; f0 = mon_ferr; o0 = mon_ovr; p0 = mon_perr;
      send_frame(vecs[k].b, vecs[k].stop, 1'b0);
      idle(30);
      chk($sformatf("v%0d rises", k), mon_rises - r0, vecs[k].exp_rises);
      if (vecs[k].exp_rises > 0) begin
        chk($sformatf("v%0d data", k), int'(hist[r0 % 16]), int'(vecs[k].exp_data));
        if (k == 0) chk("latency", rise_cyc - t_fall - 1, LAT);
      end
      chk($sformatf("v%0d frame_err", k), mon_ferr - f0, vecs[k].exp_ferr);
      chk($sformatf("v%0d overrun", k), mon_ovr - o0, 0);
      chk($sformatf("v%0d parity_err", k), mon_perr - p0, 0);
      chk($sformatf("v%0d valid popped", k), int'(u_if.data_valid), 0);
      chk($sformatf("v%0d busy idle", k), int'(u_if.busy), 0);
    end

    // Back-to-back frames with no idle gap.
    r0 = mon_rises;
    send_frame(8'hA3, 1'b1, 1'b0);
    send_frame(8'h0F, 1'b1, 1'b0);
    idle(30);
    chk("b2b rises", mon_rises - r0, 2);
    chk("b2b first", int'(hist[r0 % 16]), 8'hA3);
    chk("b2b second", int'(hist[(r0 + 1) % 16]), 8'h0F);

    // Short low glitch: rejected at the start-bit midpoint.
    r0 = mon_rises; f0 = mon_ferr; o0 = mon_ovr;
    @(negedge clk);
    rx = 1'b0;
    repeat (50) @(negedge clk);
    rx = 1'b1;
    busy_clr = 0;
    for (int i = 0; i < 110; i++) begin
      @(negedge clk);
      if (!u_if.busy) begin busy_clr = 1; break; end
    end
    chk("glitch busy cleared", busy_clr, 1);
    idle(300);
    chk("glitch rises", mon_rises - r0, 0);
    chk("glitch flags", (mon_ferr - f0) + (mon_ovr - o0), 0);

    // Stop bit low, line held low three bit times.
    r0 = mon_rises; f0 = mon_ferr;
    @(negedge clk);
    hold_bit(1'b0);
    for (int i = 0; i < 8; i++) hold_bit(8'h3C >> i);
`ifdef UART_RX_PARITY_EN
    hold_bit(^8'h3C);
`endif
    hold_bit(1'b0); hold_bit(1'b0); hold_bit(1'b0);
    chk("break frame_err", mon_ferr - f0, 1);
    chk("break busy held", int'(u_if.busy), 1);
    idle(5);
    chk("break busy released", int'(u_if.busy), 0);
    chk("break rises", mon_rises - r0, 0);

    // Overrun: consumer stalled across two frames.
    u_if.data_ready = 1'b0;
    r0 = mon_rises; o0 = mon_ovr;
    send_frame(8'h11, 1'b1, 1'b0);
    idle(30);
    send_frame(8'h22, 1'b1, 1'b0);
    idle(30);
    chk("ovr pulses", mon_ovr - o0, 1);
    chk("ovr rises", mon_rises - r0, 1);
    chk("ovr data kept", int'(u_if.data), 8'h11);
    chk("ovr valid kept", int'(u_if.data_valid), 1);

    // Reset mid-DATA of 0x7E, then a clean frame.
    @(negedge clk);
    hold_bit(1'b0);
    for (int i = 0; i < 4; i++) hold_bit(8'h7E >> i);
    chk("mid busy", int'(u_if.busy), 1);
    resetn = 1'b0;
    #1;
    chk("rst data",  int'(u_if.data), 0);
    chk("rst valid", int'(u_if.data_valid), 0);
    chk("rst busy",  int'(u_if.busy), 0);
    rx = 1'b1;
    idle(10);
    resetn = 1'b1;
    u_if.data_ready = 1'b1;
    idle(10);
    r0 = mon_rises; f0 = mon_ferr;
    send_frame(8'h81, 1'b1, 1'b0);
    idle(30);
    chk("post-rst rises", mon_rises - r0, 1);
    chk("post-rst data", int'(hist[r0 % 16]), 8'h81);
    chk("post-rst frame_err", mon_ferr - f0, 0);

`ifdef UART_RX_PARITY_EN
    // 0x07 has odd weight, so a parity bit of 0 is a mismatch.
    r0 = mon_rises; p0 = mon_perr; f0 = mon_ferr;
    send_frame(8'h07, 1'b1, 1'b1);
    idle(30);
    chk("par parity_err", mon_perr - p0, 1);
    chk("par rises", mon_rises - r0, 0);
    chk("par frame_err", mon_ferr - f0, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
